// File: rtl/dmem_pkg.sv
// Shared types for the data-memory access unit: access-size encodings,
// controller state encoding and the alignment/size legality check.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_R,
    ST_RESP
  } state_e;

  // True when the access cannot be issued: illegal size or misaligned address.
  function automatic logic access_fault(input size_e size, input logic [1:0] lsb);
    logic fault;
    case (size)
      SZ_BYTE: fault = 1'b0;
      SZ_HALF: fault = lsb[0];
      SZ_WORD: fault = |lsb;
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data-memory port: byte enables and replicated
// store data on the write side, lane extraction and sign/zero extension on
// the read side. Purely combinational.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  lsb_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store side: enables for the addressed lanes, data copied into every lane.
  always_comb begin
    be_o    = '0;
    wdata_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << lsb_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << {lsb_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      SZ_WORD: be_o = 4'b1111;
      default: ;
    endcase
  end

  // Load side: pick the little-endian lane and extend it to 32 bits.
  always_comb begin
    byte_sel = rdata_i[{lsb_i, 3'b000} +: 8];
    half_sel = lsb_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    rdata_o  = rdata_i;
    case (size_i)
      SZ_BYTE: rdata_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: rdata_o = {{16{sign_i & half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store access unit between the CPU memory stage and a word-wide data
// memory port with grant / read-valid handshakes. One request in flight.
// Optional: define DMEM_TIMEOUT_EN to abort accesses that see no grant or
// read data within TIMEOUT_CYCLES cycles of REQ + WAIT_R.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  state_e              state_q, state_d;
  logic                write_q, write_d;
  size_e               size_q, size_d;
  logic                sgn_q, sgn_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [3:0]          lane_be;
  logic [31:0]         lane_wdata;
  logic [31:0]         lane_rdata;
  logic                in_req;

  // Address bits above the memory span do not take part in the access.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  dmem_lane_align u_lane_align (
    .size_i  (size_q),
    .lsb_i   (addr_q[1:0]),
    .sign_i  (sgn_q),
    .wdata_i (wdata_q),
    .rdata_i (mem_rdata),
    .be_o    (lane_be),
    .wdata_o (lane_wdata),
    .rdata_o (lane_rdata)
  );

  assign in_req    = (state_q == ST_REQ);
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_req   = in_req;
  assign mem_we    = in_req & write_q;
  assign mem_be    = in_req ? lane_be : '0;
  assign mem_addr  = in_req ? addr_q[ADDR_W+1:2] : '0;
  assign mem_wdata = in_req ? lane_wdata : '0;

  // State and latched-request registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic; response registers change only on entry to RESP so
  // they hold their value until the next response.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef DMEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = size_e'(req_size);
          sgn_d   = req_signed;
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          if (access_fault(size_e'(req_size), req_addr[1:0])) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ST_REQ;
`ifdef DMEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          if (write_q) begin
            state_d = ST_RESP;
            err_d   = 1'b0;
            rdata_d = '0;
          end else begin
            state_d = ST_WAIT_R;
`ifdef DMEM_TIMEOUT_EN
            cnt_d   = cnt_q + CNT_W'(1);
`endif
          end
        end
`ifdef DMEM_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_WAIT_R: begin
        if (mem_rvalid) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = lane_rdata;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: a transaction-level model turns
// each request into expected cycle windows (memory request, response) and
// expected port values; a negedge process compares the DUT every cycle.
module tb_dmem_access_unit;

  localparam int AW = 10;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]    req_size = '0;
  logic [31:0]   req_addr = '0, req_wdata = '0;
  logic          rsp_valid, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          mem_req, mem_gnt = 1'b0, mem_we, mem_rvalid = 1'b0;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata = '0;

  dmem_access_unit #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_be_f(input logic [1:0] sz, input logic [31:0] ad);
    int n, off;
    logic [3:0] be;
    n = 1 << sz;
    off = int'(ad[1:0]);
    for (int i = 0; i < 4; i++) be[i] = ((i / n) == (off / n));
    return be;
  endfunction

  function automatic logic [31:0] m_wd_f(input logic [1:0] sz, input logic [31:0] w);
    int n;
    logic [31:0] o;
    n = 1 << sz;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = w[8*(i % n) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] m_ld_f(input logic [1:0] sz, input logic sg,
                                         input logic [31:0] ad, input logic [31:0] rd);
    int n, off;
    logic [31:0] v, mask;
    n = 1 << sz;
    off = int'(ad[1:0]);
    v = rd >> (8 * off);
    mask = (n >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v = v & mask;
    if (sg && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Expected windows (cycle numbers) and values for the current transaction.
  int req_lo = -100, req_hi = -100, rsp_at = -100, busy_lo = -100, busy_hi = -100;
  logic          m_we = 1'b0, m_err = 1'b0;
  logic [3:0]    m_be = '0;
  logic [31:0]   m_wd = '0, m_rdata = '0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   hold_rd = '0;
  logic          hold_err = 1'b0;
  logic [3:0]    cap_be = '0;
  logic [31:0]   cap_wd = '0;
  logic [AW-1:0] cap_addr = '0;
  int            last_rsp_cyc = -1;

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    logic e_req, e_rsp, e_rdy;
    if (!rst) begin
      hold_rd  = '0;
      hold_err = 1'b0;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_mem_req",   32'(mem_req),   32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata,      32'd0);
      chk("rst_rsp_err",   32'(rsp_err),   32'd0);
      chk("rst_mem_be",    32'(mem_be),    32'd0);
      chk("rst_mem_we",    32'(mem_we),    32'd0);
    end else begin
      e_req = (cyc >= req_lo) && (cyc <= req_hi);
      e_rsp = (cyc == rsp_at);
      e_rdy = !((cyc >= busy_lo) && (cyc <= busy_hi));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      if (e_req) begin
        chk("mem_addr",  32'(mem_addr), 32'(m_addr));
        chk("mem_be",    32'(mem_be),   32'(m_be));
        chk("mem_we",    32'(mem_we),   32'(m_we));
        chk("mem_wdata", mem_wdata,     m_wd);
        cap_be   = mem_be;
        cap_wd   = mem_wdata;
        cap_addr = mem_addr;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      if (rsp_valid) last_rsp_cyc = cyc;
      if (e_rsp) begin
        hold_rd  = m_rdata;
        hold_err = m_err;
      end
      chk("rsp_rdata", rsp_rdata,    hold_rd);
      chk("rsp_err",   32'(rsp_err), 32'(hold_err));
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic rand_req_fields();
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      req_valid  = 1'b0;
      rand_req_fields();
      mem_gnt    = 1'($urandom);
      mem_rvalid = 1'($urandom);
      mem_rdata  = $urandom;
      @(posedge clk); #1;
    end
  endtask

  // g: grant delay in cycles (-1 = never); r: read-valid delay after grant (-1 = never).
  task automatic run_txn(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd,
                         input int g, input int r, input logic [31:0] rd);
    int a, gc, rvc, n;
    logic e;
    a = cyc;
    n = 1 << sz;
    e = (sz == 2'd3) || ((int'(ad[1:0]) % n) != 0);
    m_we   = w;
    m_be   = m_be_f(sz, ad);
    m_wd   = m_wd_f(sz, wd);
    m_addr = AW'(ad >> 2);
    if (e) begin
      req_lo = -100; req_hi = -100; rsp_at = a + 1; m_err = 1'b1; m_rdata = '0;
    end else if (g < 0) begin
      req_lo = a + 1; req_hi = a + TO; rsp_at = a + TO + 1; m_err = 1'b1; m_rdata = '0;
    end else begin
      req_lo = a + 1; req_hi = a + 1 + g;
      if (w) begin
        rsp_at = a + 2 + g; m_err = 1'b0; m_rdata = '0;
      end else if (r < 0) begin
        rsp_at = a + 1 + TO; m_err = 1'b1; m_rdata = '0;
      end else begin
        rsp_at = a + 2 + g + r; m_err = 1'b0; m_rdata = m_ld_f(sz, sg, ad, rd);
      end
    end
    busy_lo = a + 1;
    busy_hi = rsp_at;
    gc  = (g < 0) ? rsp_at : a + 1 + g;
    rvc = (r < 0) ? rsp_at : a + 1 + g + r;
    for (int c = a; c <= rsp_at; c++) begin
      req_valid = (c == a);
      if (c == a) begin
        req_write = w; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
      end else begin
        rand_req_fields();
      end
      mem_rdata = $urandom;
      if (!e && g >= 0 && c == gc)            mem_gnt = 1'b1;
      else if (!e && c >= a + 1 && c < gc)    mem_gnt = 1'b0;
      else                                    mem_gnt = 1'($urandom);
      if (!e && !w && g >= 0 && r >= 0 && c == rvc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
      end else if (!e && !w && g >= 0 && c >= a + 2 + g && c < rvc) begin
        mem_rvalid = 1'b0;
      end else begin
        mem_rvalid = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  int t0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    // Store word: mem_addr 4, all lanes, 2-cycle response.
    t0 = cyc;
    run_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 0, '0);
    chk("sw_addr", 32'(cap_addr), 32'd4);
    chk("sw_be", 32'(cap_be), 32'hF);
    chk("sw_wdata", cap_wd, 32'hDEADBEEF);
    chk("sw_latency", 32'(last_rsp_cyc - t0), 32'd2);
    chk("sw_rdata", rsp_rdata, 32'd0);

    // Store byte to lane 3.
    run_txn(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5, 0, 0, '0);
    chk("sb_be", 32'(cap_be), 32'h8);
    chk("sb_wdata", cap_wd, 32'hA5A5A5A5);

    // Byte / half loads with extension.
    t0 = cyc;
    run_txn(1'b0, 2'b00, 1'b1, 32'h1, $urandom, 0, 1, 32'h80FF7F01);
    chk("lb_s1", rsp_rdata, 32'h0000007F);
    chk("lb_latency", 32'(last_rsp_cyc - t0), 32'd3);
    run_txn(1'b0, 2'b00, 1'b1, 32'h3, $urandom, 0, 1, 32'h80FF7F01);
    chk("lb_s3", rsp_rdata, 32'hFFFFFF80);
    run_txn(1'b0, 2'b00, 1'b0, 32'h2, $urandom, 1, 2, 32'h80FF7F01);
    chk("lbu_2", rsp_rdata, 32'h000000FF);
    run_txn(1'b0, 2'b01, 1'b1, 32'h2, $urandom, 0, 1, 32'h8001FFFF);
    chk("lh_s2", rsp_rdata, 32'hFFFF8001);

    // Misaligned / illegal: one-cycle error response, no memory access.
    t0 = cyc;
    run_txn(1'b0, 2'b01, 1'b0, 32'h5, $urandom, 0, 1, '0);
    chk("mis_half_err", 32'(rsp_err), 32'd1);
    chk("mis_half_latency", 32'(last_rsp_cyc - t0), 32'd1);
    run_txn(1'b1, 2'b10, 1'b0, 32'h6, $urandom, 0, 1, '0);
    chk("mis_word_err", 32'(rsp_err), 32'd1);
    chk("mis_word_rdata", rsp_rdata, 32'd0);
    run_txn(1'b0, 2'b11, 1'b0, 32'h0, $urandom, 0, 1, '0);
    chk("ill_size_err", 32'(rsp_err), 32'd1);

    // Delayed grant and read data; request held stable throughout.
    t0 = cyc;
    run_txn(1'b0, 2'b10, 1'b0, 32'h40, $urandom, 3, 2, 32'h12345678);
    chk("slow_rdata", rsp_rdata, 32'h12345678);
    chk("slow_latency", 32'(last_rsp_cyc - t0), 32'd7);

    // Reset pulse while waiting for read data: no response, late rvalid ignored.
    t0 = cyc;
    m_we = 1'b0; m_be = 4'hF; m_addr = AW'(32'h80 >> 2); m_wd = 32'h0BADF00D;
    req_lo = t0 + 1; req_hi = t0 + 4; rsp_at = -100;
    busy_lo = t0 + 1; busy_hi = 1 << 30;
    for (int c = 0; c < 5; c++) begin
      req_valid = (c == 0);
      req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'h80; req_wdata = 32'h0BADF00D;
      mem_gnt = (c == 4);
      mem_rvalid = 1'b0;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    mem_gnt = 1'b0;
    req_hi = t0 + 4;
    busy_hi = t0 + 4;
    rst = 1'b0;
    #1;
    chk("rst_async_mem_req", 32'(mem_req), 32'd0);
    chk("rst_async_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    idle(5);
    chk("rst_no_rsp", 32'(last_rsp_cyc < t0), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic        w, sg;
      logic [1:0]  sz, m;
      logic [31:0] ad;
      w  = 1'($urandom);
      sg = 1'($urandom);
      sz = 2'($urandom);
      ad = $urandom;
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) begin
        m = 2'((1 << sz) - 1);
        ad[1:0] = ad[1:0] & ~m;
      end
      run_txn(w, sz, sg, ad, $urandom, int'($urandom_range(0, 3)),
              int'($urandom_range(1, 4)), $urandom);
      idle(int'($urandom_range(0, 2)));
    end

`ifdef DMEM_TIMEOUT_EN
    t0 = cyc;
    run_txn(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, -1, 0, '0);
    chk("to_gnt_err", 32'(rsp_err), 32'd1);
    chk("to_gnt_latency", 32'(last_rsp_cyc - t0), 32'(TO + 1));
    t0 = cyc;
    run_txn(1'b0, 2'b10, 1'b0, 32'h24, $urandom, 2, -1, '0);
    chk("to_rvalid_err", 32'(rsp_err), 32'd1);
    chk("to_rvalid_rdata", rsp_rdata, 32'd0);
    chk("to_rvalid_latency", 32'(last_rsp_cyc - t0), 32'(TO + 1));
`endif

    idle(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
